// File: rtl/ram_loader.sv
// Serial boot loader: parses SYNC/ADDR/LEN/payload/CHK frames from a valid/ready byte
// stream and writes the payload into RAM one byte per two clocks.
module ram_loader #(
  parameter int unsigned RAM_BUS_SIZE = 12,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT      = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [RAM_BUS_SIZE-1:0] address_bus,
  inout  wire  [7:0]              data_bus,
  output logic                    enable,
  output logic                    write,
  output logic                    read,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    StIdle, StAddrLo, StAddrHi, StLenLo, StLenHi, StData, StWrite, StCheck, StDone, StError
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              lo_q, lo_d;
  logic [RAM_BUS_SIZE-1:0] addr_q, addr_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [7:0]              wdata_q, wdata_d;
  logic [7:0]              sum_q, sum_d;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  logic                    in_ready_q, in_ready_d;

  logic        xfer;
  logic [15:0] word;
  logic [7:0]  sum_next;
  logic        tmo_run;
  logic        wr_act;

  assign xfer     = in_valid && in_ready_q;
  assign word     = {in_data, lo_q};
  assign sum_next = sum_q + in_data;
  assign tmo_run  = state_q inside {StAddrLo, StAddrHi, StLenLo, StLenHi, StData, StCheck};

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    sum_d   = sum_q;
    tmo_d   = '0;

    case (state_q)
      StIdle: begin
        if (xfer && in_data == SYNC_BYTE) begin
          state_d = StAddrLo;
          sum_d   = 8'd0;
        end
      end
      StAddrLo: begin
        if (xfer) begin
          lo_d    = in_data;
          sum_d   = sum_next;
          state_d = StAddrHi;
        end
      end
      StAddrHi: begin
        if (xfer) begin
          addr_d  = word[RAM_BUS_SIZE-1:0];
          sum_d   = sum_next;
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (xfer) begin
          lo_d    = in_data;
          sum_d   = sum_next;
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (xfer) begin
          cnt_d   = word;
          sum_d   = sum_next;
          state_d = (word == 16'd0) ? StCheck : StData;
        end
      end
      StData: begin
        if (xfer) begin
          wdata_d = in_data;
          sum_d   = sum_next;
          state_d = StWrite;
        end
      end
      StWrite: begin
        addr_d  = addr_q + RAM_BUS_SIZE'(1);
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q == 16'd1) ? StCheck : StData;
      end
      StCheck: begin
        if (xfer) state_d = (sum_next == 8'd0) ? StDone : StError;
      end
      StDone:  state_d = StIdle;
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Idle-gap watchdog; any accepted byte restarts it.
    if (tmo_run && !xfer) begin
      if (tmo_q == TmoW'(TIMEOUT - 1)) begin
        state_d = StError;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end

    in_ready_d = state_d inside {StIdle, StAddrLo, StAddrHi, StLenLo, StLenHi, StData, StCheck};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      lo_q       <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      sum_q      <= '0;
      tmo_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      sum_q      <= sum_d;
      tmo_q      <= tmo_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Reset kills a strobe already in flight so no partial write lands in RAM.
  assign wr_act      = (state_q == StWrite) && !reset;
  assign enable      = wr_act;
  assign write       = wr_act;
  assign read        = 1'b0;
  assign address_bus = wr_act ? addr_q : '0;
  assign data_bus    = wr_act ? wdata_q : 8'bz;
  assign in_ready    = in_ready_q;
  assign busy        = !(state_q inside {StIdle, StDone, StError});
  assign done        = (state_q == StDone);
  assign error       = (state_q == StError);

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: directed and randomized frames checked against a
// frame-level model of expected RAM writes and done/error outcome.
module tb_ram_loader;

  localparam int unsigned Aw = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [Aw-1:0] address_bus;
  wire  [7:0]    data_bus;
  logic          enable, write, read, busy, done, error;

  int total = 0;
  int bad   = 0;

  // Monitor state
  logic [Aw-1:0] wr_a[$];
  logic [7:0]    wr_d[$];
  int            done_cnt = 0;
  int            err_cnt  = 0;
  bit            both_seen = 1'b0;
  bit            rdy_in_wr = 1'b0;
  bit            addr_leak = 1'b0;
  bit            read_seen = 1'b0;

  logic [7:0]    pl_q[$];

  ram_loader #(
    .RAM_BUS_SIZE(Aw),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT     (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .address_bus(address_bus),
    .data_bus   (data_bus),
    .enable     (enable),
    .write      (write),
    .read       (read),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (enable && write) begin
      wr_a.push_back(address_bus);
      wr_d.push_back(data_bus);
      if (in_ready) rdy_in_wr = 1'b1;
    end else if (address_bus != '0) begin
      addr_leak = 1'b1;
    end
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done && error) both_seen = 1'b1;
    if (read) read_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_a.delete();
    wr_d.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  // Offer a byte until it is accepted; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int budget = 200;
    bit sent   = 1'b0;
    while (!sent && budget > 0) begin
      @(negedge clk);
      budget--;
      if (rnd && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        if (in_ready) sent = 1'b1;
      end
    end
    if (!sent) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Builds a frame from pl_q, sends it, and compares writes/outcome with the model.
  task automatic run_frame(input string tag, input logic [15:0] addr, input bit corrupt,
                           input bit rnd);
    logic [7:0]    fr[$];
    logic [7:0]    sum;
    logic [7:0]    cb;
    logic [15:0]   len;
    logic [Aw-1:0] ea;
    len = 16'(pl_q.size());
    fr  = {8'hA5, addr[7:0], addr[15:8], len[7:0], len[15:8]};
    foreach (pl_q[i]) fr.push_back(pl_q[i]);
    sum = 8'd0;
    for (int i = 1; i < fr.size(); i++) sum = sum + fr[i];
    cb = 8'd0 - sum;
    if (corrupt) cb = cb + 8'd1;
    fr.push_back(cb);

    clear_mon();
    chk({tag, "_busy_pre"}, busy, 1'b0);
    foreach (fr[i]) begin
      send_byte(fr[i], rnd);
      if (i == 0) chk({tag, "_busy_sync"}, busy, 1'b1);
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    chk({tag, "_nwr"}, wr_a.size(), pl_q.size());
    for (int i = 0; i < pl_q.size() && i < wr_a.size(); i++) begin
      ea = addr[Aw-1:0] + Aw'(i);
      chk({tag, "_wa"}, wr_a[i], ea);
      chk({tag, "_wd"}, wr_d[i], pl_q[i]);
    end
    chk({tag, "_done"}, done_cnt, corrupt ? 0 : 1);
    chk({tag, "_err"}, err_cnt, corrupt ? 1 : 0);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_rdy_end"}, in_ready, 1'b1);
  endtask

  initial begin
    int k_err;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_enable", enable, 1'b0);
    chk("rst_write", write, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_addr", address_bus, 12'h000);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 1'b1);

    // Good frame, in_valid held high
    pl_q = {8'h11, 8'h22, 8'h33};
    run_frame("good", 16'h0100, 1'b0, 1'b0);

    // Garbage then zero-length frame
    addr_leak = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h5A, 1'b0);
    in_valid = 1'b0;
    chk("garbage_busy", busy, 1'b0);
    pl_q.delete();
    run_frame("zlen", 16'h0010, 1'b0, 1'b0);
    chk("zlen_addr_quiet", addr_leak, 1'b0);

    // Bad checksum: bytes still land, error pulses
    pl_q = {8'h11, 8'h22, 8'h33};
    run_frame("badchk", 16'h0100, 1'b1, 1'b0);

    // Address wrap
    pl_q = {8'hAA, 8'hBB};
    run_frame("wrap", 16'h0FFF, 1'b0, 1'b0);

    // Randomized frames with backpressure gaps; upper address bits ignored
    for (int f = 0; f < 4; f++) begin
      pl_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) pl_q.push_back(8'($urandom));
      run_frame("rand", 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Timeout after partial header
    clear_mon();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    in_valid = 1'b0;
    k_err = 0;
    for (int k = 1; k <= 40 && k_err == 0; k++) begin
      @(posedge clk);
      #1;
      if (error) k_err = k;
    end
    chk("tmo_cycles", k_err, 16);
    @(posedge clk);
    #1;
    chk("tmo_idle_busy", busy, 1'b0);
    chk("tmo_idle_rdy", in_ready, 1'b1);
    chk("tmo_err_cnt", err_cnt, 1);
    chk("tmo_done_cnt", done_cnt, 0);
    pl_q = {8'h11, 8'h22, 8'h33};
    run_frame("post_tmo", 16'h0100, 1'b0, 1'b0);

    // Reset during the second payload write, with random valid toggling
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    @(posedge clk);
    #1;
    send_byte(8'h22, 1'b1);
    reset    = 1'b1;
    in_valid = 1'($urandom_range(0, 1));
    #1;
    chk("mrst_wr_suppr", {enable, write}, 2'b00);
    chk("mrst_addr_suppr", address_bus, 12'h000);
    @(posedge clk);
    #1;
    chk("mrst_in_ready", in_ready, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_outs", {enable, write, done, error}, 4'b0000);
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mrst_nwr", wr_a.size(), 1);
    if (wr_a.size() > 0) begin
      chk("mrst_wa", wr_a[0], 12'h100);
      chk("mrst_wd", wr_d[0], 8'h11);
    end
    chk("mrst_done", done_cnt, 0);
    chk("mrst_err", err_cnt, 0);
    chk("mrst_rdy", in_ready, 1'b1);
    pl_q = {8'h11, 8'h22, 8'h33};
    run_frame("retx", 16'h0100, 1'b0, 1'b1);

    // Global invariants
    chk("done_error_excl", both_seen, 1'b0);
    chk("rdy_low_in_write", rdy_in_wr, 1'b0);
    chk("read_never", read_seen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
